// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Covers state codes, opcode/funct values, ALU ops, datapath select codes and the decode bundle.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;
    localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'b000011;
    localparam logic [FUNC_W-1:0] FN_JR  = 6'b001000;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

    localparam logic [SEL_W-1:0] ASRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] ASRCB_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] ASRCB_IMM  = 2'b10;
    localparam logic [SEL_W-1:0] ASRCB_BR   = 2'b11;

    localparam logic [SEL_W-1:0] PCS_ALU  = 2'b00;
    localparam logic [SEL_W-1:0] PCS_BR   = 2'b01;
    localparam logic [SEL_W-1:0] PCS_RS   = 2'b10;
    localparam logic [SEL_W-1:0] PCS_JUMP = 2'b11;

    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
        logic i_addi, i_andi, i_ori, i_xori, i_lui;
        logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
        logic is_rtype_alu, is_itype_alu, is_branch, is_mem, is_jump, illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/func to one-hot instruction flags and class flags.
module mc_decode import mc_pkg::*; (
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    output dec_t              dec
);

    logic rtype;

    always_comb begin
        dec   = '0;
        rtype = (op == OP_RTYPE);

        dec.i_add  = rtype && (func == FN_ADD);
        dec.i_sub  = rtype && (func == FN_SUB);
        dec.i_and  = rtype && (func == FN_AND);
        dec.i_or   = rtype && (func == FN_OR);
        dec.i_xor  = rtype && (func == FN_XOR);
        dec.i_sll  = rtype && (func == FN_SLL);
        dec.i_srl  = rtype && (func == FN_SRL);
        dec.i_sra  = rtype && (func == FN_SRA);
        dec.i_jr   = rtype && (func == FN_JR);
        dec.i_addi = (op == OP_ADDI);
        dec.i_andi = (op == OP_ANDI);
        dec.i_ori  = (op == OP_ORI);
        dec.i_xori = (op == OP_XORI);
        dec.i_lui  = (op == OP_LUI);
        dec.i_lw   = (op == OP_LW);
        dec.i_sw   = (op == OP_SW);
        dec.i_beq  = (op == OP_BEQ);
        dec.i_bne  = (op == OP_BNE);
        dec.i_j    = (op == OP_J);
        dec.i_jal  = (op == OP_JAL);

        dec.is_rtype_alu = dec.i_add | dec.i_sub | dec.i_and | dec.i_or | dec.i_xor
                         | dec.i_sll | dec.i_srl | dec.i_sra;
        dec.is_itype_alu = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui;
        dec.is_branch    = dec.i_beq | dec.i_bne;
        dec.is_mem       = dec.i_lw | dec.i_sw;
        dec.is_jump      = dec.i_j | dec.i_jal | dec.i_jr;
        // Anything outside the supported subset retires as a NOP after ID.
        dec.illegal      = ~(dec.is_rtype_alu | dec.is_itype_alu | dec.is_branch
                           | dec.is_mem | dec.is_jump);
    end

endmodule

// File: rtl/mc_cu.sv
// Multicycle control unit: 5-state FSM sequencing shared ALU, unified memory port, PC and IR.
// Outputs are combinational from state and inputs; write enables are squashed during reset.
module mc_cu import mc_pkg::*; (
    input  logic                clock,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNC_W-1:0]   func,
    input  logic                z,
    input  logic                mem_ready,
    output logic                wpc,
    output logic                wir,
    output logic                iord,
    output logic                wmem,
    output logic                wreg,
    output logic                regrt,
    output logic                m2reg,
    output logic                jal,
    output logic [ALUC_W-1:0]   aluc,
    output logic                shift,
    output logic                alusrca,
    output logic [SEL_W-1:0]    alusrcb,
    output logic                sext,
    output logic [SEL_W-1:0]    pcsource,
    output logic [STATE_W-1:0]  state
);

    state_t            cur, nxt;
    dec_t              dec;
    logic [ALUC_W-1:0] alu_op;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    always_ff @(posedge clock) begin
        if (reset) cur <= S_IF;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = S_IF;
        case (cur)
            S_IF:  nxt = mem_ready ? S_ID : S_IF;
            S_ID:  nxt = (dec.is_jump || dec.illegal) ? S_IF : S_EXE;
            S_EXE: begin
                if (dec.is_branch)   nxt = S_IF;
                else if (dec.is_mem) nxt = S_MEM;
                else                 nxt = S_WB;
            end
            S_MEM: begin
                if (!mem_ready)      nxt = S_MEM;
                else if (dec.i_lw)   nxt = S_WB;
                else                 nxt = S_IF;
            end
            S_WB:  nxt = S_IF;
            default: nxt = S_IF;
        endcase
    end

    // ALU operation selected by the decoded R/I-type instruction.
    always_comb begin
        alu_op = ALUC_ADD;
        if (dec.i_sub)                    alu_op = ALUC_SUB;
        else if (dec.i_and || dec.i_andi) alu_op = ALUC_AND;
        else if (dec.i_or  || dec.i_ori)  alu_op = ALUC_OR;
        else if (dec.i_xor || dec.i_xori) alu_op = ALUC_XOR;
        else if (dec.i_lui)               alu_op = ALUC_LUI;
        else if (dec.i_sll)               alu_op = ALUC_SLL;
        else if (dec.i_srl)               alu_op = ALUC_SRL;
        else if (dec.i_sra)               alu_op = ALUC_SRA;
    end

    always_comb begin
        wpc      = 1'b0;
        wir      = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        aluc     = ALUC_ADD;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ASRCB_REG;
        sext     = 1'b0;
        pcsource = PCS_ALU;
        case (cur)
            S_IF: begin
                alusrcb = ASRCB_FOUR;
                wpc     = mem_ready;
                wir     = mem_ready;
            end
            S_ID: begin
                alusrcb = ASRCB_BR;
                sext    = 1'b1;
                if (dec.i_j || dec.i_jal) begin
                    wpc      = 1'b1;
                    pcsource = PCS_JUMP;
                end
                if (dec.i_jal) begin
                    wreg = 1'b1;
                    jal  = 1'b1;
                end
                if (dec.i_jr) begin
                    wpc      = 1'b1;
                    pcsource = PCS_RS;
                end
            end
            S_EXE: begin
                if (dec.is_rtype_alu) begin
                    alusrca = 1'b1;
                    aluc    = alu_op;
                    shift   = dec.i_sll | dec.i_srl | dec.i_sra;
                end else if (dec.is_itype_alu) begin
                    alusrcb = ASRCB_IMM;
                    sext    = dec.i_addi | dec.i_lui;
                    aluc    = alu_op;
                end else if (dec.is_branch) begin
                    aluc     = ALUC_SUB;
                    pcsource = PCS_BR;
                    wpc      = dec.i_beq ? z : ~z;
                end else if (dec.is_mem) begin
                    alusrcb = ASRCB_IMM;
                    sext    = 1'b1;
                end
            end
            // wmem depends only on state and op, so it holds steady across wait cycles.
            S_MEM: begin
                iord = 1'b1;
                wmem = dec.i_sw;
            end
            S_WB: begin
                wreg  = 1'b1;
                regrt = dec.is_itype_alu | dec.i_lw;
                m2reg = dec.i_lw;
            end
            default: ;
        endcase
        if (reset) begin
            wpc  = 1'b0;
            wir  = 1'b0;
            wmem = 1'b0;
            wreg = 1'b0;
        end
    end

    assign state = cur;

endmodule
